// File: rtl/lcd_stream_tx.sv
// lcd_stream_tx: replays a line-ordered 15-bit frame store as an LCD pixel
// stream with DMG/CGB dot timing (456 dots x 154 lines, modes 2/3/0/1).
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   ce               dot enable (one dot per clk with ce=1)
//   enable           LCD on; low holds the block idle
//   pattern_sel      test-pattern select (LCD_TX_PATTERN_EN builds only)
//   ram_addr/ram_rd  frame-store read port; ram_q valid on the next clk
//   data/clkena      pixel output and its one-clk valid strobe
//   mode/ly/on       timing state (mode 0 hblank, 1 vblank, 2 OAM, 3 xfer)
//   vblank_pulse     one clk on entry to line VIS_H
//   frame_cnt        wrapping 5-bit frame counter
//
// Optional feature macro: LCD_TX_PATTERN_EN. When defined, pattern_sel=1
// replaces returned pixels with {frame_cnt, ly[7:3], x[7:3]}.
module lcd_stream_tx #(
    parameter int LINE_DOTS   = 456,
    parameter int OAM_DOTS    = 80,
    parameter int XFER_DOTS   = 172,
    parameter int VIS_W       = 160,
    parameter int VIS_H       = 144,
    parameter int TOTAL_LINES = 154
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        enable,
    input  logic        pattern_sel,
    output logic [14:0] ram_addr,
    output logic        ram_rd,
    input  logic [14:0] ram_q,
    output logic [14:0] data,
    output logic        clkena,
    output logic [1:0]  mode,
    output logic        on,
    output logic [7:0]  ly,
    output logic        vblank_pulse,
    output logic [4:0]  frame_cnt
);

    localparam logic [8:0] L_DOT_LAST = 9'(LINE_DOTS - 1);
    localparam logic [8:0] L_OAM      = 9'(OAM_DOTS);
    localparam logic [8:0] L_XEND     = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [8:0] L_VISW     = 9'(VIS_W);
    localparam logic [7:0] L_LY_LAST  = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] L_VISH     = 8'(VIS_H);

    typedef enum logic [1:0] {
        MODE_HBL  = 2'd0,
        MODE_VBL  = 2'd1,
        MODE_OAM  = 2'd2,
        MODE_XFER = 2'd3
    } mode_t;

    // r_run is clear until the first ce after enable/reset; that ce
    // lands on line 0, dot 0 instead of advancing the counters.
    logic        r_run;
    logic [8:0]  r_dot;
    logic [7:0]  r_ly;
    mode_t       r_mode;
    logic        r_on;
    logic        r_clkena;
    logic        r_ram_rd;
    logic [14:0] r_data;
    logic [14:0] r_ram_addr;
    logic [14:0] r_pix_addr;
    logic [4:0]  r_frame_cnt;
    logic        r_vblank_pulse;

    logic [8:0]  w_dot_nx;
    logic [7:0]  w_ly_nx;
    logic        w_line_wrap;
    logic        w_frame_wrap;
    mode_t       w_mode_nx;
    logic [8:0]  w_xoff;
    logic        w_fetch;
    logic        w_vbl_entry;
    logic [14:0] w_ret_data;

    // Next dot/line position if this cycle carries a ce.
    always_comb begin
        w_dot_nx     = r_dot;
        w_ly_nx      = r_ly;
        w_line_wrap  = 1'b0;
        w_frame_wrap = 1'b0;
        if (!r_run) begin
            w_dot_nx = '0;
            w_ly_nx  = '0;
        end else if (r_dot == L_DOT_LAST) begin
            w_dot_nx    = '0;
            w_line_wrap = 1'b1;
            if (r_ly == L_LY_LAST) begin
                w_ly_nx      = '0;
                w_frame_wrap = 1'b1;
            end else begin
                w_ly_nx = r_ly + 8'd1;
            end
        end else begin
            w_dot_nx = r_dot + 9'd1;
        end
    end

    // Mode decode from the updated position; fetch only on the first
    // VIS_W dots of mode 3.
    always_comb begin
        w_mode_nx = MODE_HBL;
        if (w_ly_nx >= L_VISH) begin
            w_mode_nx = MODE_VBL;
        end else if (w_dot_nx < L_OAM) begin
            w_mode_nx = MODE_OAM;
        end else if (w_dot_nx < L_XEND) begin
            w_mode_nx = MODE_XFER;
        end
        w_xoff      = w_dot_nx - L_OAM;
        w_fetch     = (w_mode_nx == MODE_XFER) && (w_xoff < L_VISW);
        w_vbl_entry = w_line_wrap && (w_ly_nx == L_VISH);
    end

`ifdef LCD_TX_PATTERN_EN
    // Pattern word captured at issue so it returns with the same
    // one-clk latency as the RAM data.
    logic        r_pat_sel;
    logic [14:0] r_pat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pat_sel <= 1'b0;
            r_pat     <= '0;
        end else if (!enable) begin
            r_pat_sel <= 1'b0;
            r_pat     <= '0;
        end else if (ce && w_fetch) begin
            r_pat_sel <= pattern_sel;
            r_pat     <= {r_frame_cnt, w_ly_nx[7:3], w_xoff[7:3]};
        end
    end

    assign w_ret_data = r_pat_sel ? r_pat : ram_q;
`else
    logic w_unused_pat;

    assign w_unused_pat = pattern_sel;
    assign w_ret_data   = ram_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run          <= 1'b0;
            r_dot          <= '0;
            r_ly           <= '0;
            r_mode         <= MODE_HBL;
            r_on           <= 1'b0;
            r_clkena       <= 1'b0;
            r_ram_rd       <= 1'b0;
            r_data         <= '0;
            r_ram_addr     <= '0;
            r_pix_addr     <= '0;
            r_frame_cnt    <= '0;
            r_vblank_pulse <= 1'b0;
        end else begin
            r_on           <= enable;
            r_clkena       <= 1'b0;
            r_ram_rd       <= 1'b0;
            r_vblank_pulse <= 1'b0;
            if (!enable) begin
                // Idle; a read still in flight is dropped here.
                r_run      <= 1'b0;
                r_dot      <= '0;
                r_ly       <= '0;
                r_mode     <= MODE_HBL;
                r_data     <= '0;
                r_ram_addr <= '0;
                r_pix_addr <= '0;
            end else begin
                if (r_ram_rd) begin
                    r_clkena <= 1'b1;
                    r_data   <= w_ret_data;
                end
                if (ce) begin
                    r_run  <= 1'b1;
                    r_dot  <= w_dot_nx;
                    r_ly   <= w_ly_nx;
                    r_mode <= w_mode_nx;
                    if (w_vbl_entry) begin
                        r_vblank_pulse <= 1'b1;
                    end
                    if (w_frame_wrap) begin
                        r_frame_cnt <= r_frame_cnt + 5'd1;
                        r_pix_addr  <= '0;
                    end else if (w_fetch) begin
                        r_ram_rd   <= 1'b1;
                        r_ram_addr <= r_pix_addr;
                        r_pix_addr <= r_pix_addr + 15'd1;
                    end
                end
            end
        end
    end

    assign ram_addr     = r_ram_addr;
    assign ram_rd       = r_ram_rd;
    assign data         = r_data;
    assign clkena       = r_clkena;
    assign mode         = r_mode;
    assign on           = r_on;
    assign ly           = r_ly;
    assign vblank_pulse = r_vblank_pulse;
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_lcd_stream_tx.sv
// tb_lcd_stream_tx: randomized scoreboard bench for lcd_stream_tx.
// Reference model tracks dots/lines from ce/enable and queues pixels.
module tb_lcd_stream_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        enable;
    logic        pattern_sel;
    logic [14:0] ram_addr;
    logic        ram_rd;
    logic [14:0] ram_q;
    logic [14:0] data;
    logic        clkena;
    logic [1:0]  mode;
    logic        on;
    logic [7:0]  ly;
    logic        vblank_pulse;
    logic [4:0]  frame_cnt;

    lcd_stream_tx dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ce           (ce),
        .enable       (enable),
        .pattern_sel  (pattern_sel),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_q        (ram_q),
        .data         (data),
        .clkena       (clkena),
        .mode         (mode),
        .on           (on),
        .ly           (ly),
        .vblank_pulse (vblank_pulse),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    // Frame store contents: address scrambled by a per-phase salt.
    logic [14:0] salt;
    assign ram_q = ram_addr ^ salt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [14:0] exp_q[$];

    // Reference model state (after the most recent clk edge).
    bit m_on, m_run, m_vbp, m_rd;
    int m_dot, m_ly, m_frame, m_mode, m_addr;

    int n_clkena = 0;
    logic [14:0] last_data = '0;
    int first_cyc = -1;
    int start_cyc = 0;
    int n_vbp = 0;

    task automatic chk(input string name, input longint act,
                       input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int mode_of(input int l, input int d);
        if (l >= 144) return 1;
        if (d < 80) return 2;
        if (d < 252) return 3;
        return 0;
    endfunction

    function automatic logic [14:0] expv(input int pix, input int l,
                                         input int x, input int f,
                                         input bit ps);
        logic [7:0] lv;
        logic [7:0] xv;
        logic [4:0] fv;
        lv = 8'(l);
        xv = 8'(x);
        fv = 5'(f);
`ifdef LCD_TX_PATTERN_EN
        if (ps) return {fv, lv[7:3], xv[7:3]};
`else
        if (ps && (lv == 8'hff) && (xv == 8'hff) && (fv == 5'h1f))
            return 15'(pix);
`endif
        return 15'(pix) ^ salt;
    endfunction

    task automatic check_state();
        logic [32:0] a;
        logic [32:0] e;
        a = {on, ly, mode, vblank_pulse, frame_cnt, ram_rd,
             ram_rd ? ram_addr : 15'd0};
        e = {m_on, 8'(m_ly), 2'(m_mode), m_vbp, 5'(m_frame), m_rd,
             m_rd ? 15'(m_addr) : 15'd0};
        chk("state{on,ly,mode,vbp,frame,rd,addr}", a, e);
    endtask

    task automatic predict(input bit en, input bit c);
        m_on  = en;
        m_vbp = 1'b0;
        m_rd  = 1'b0;
        if (!en) begin
            m_run  = 1'b0;
            m_dot  = 0;
            m_ly   = 0;
            m_mode = 0;
            exp_q.delete();
        end else if (c) begin
            if (!m_run) begin
                m_run = 1'b1;
                m_dot = 0;
                m_ly  = 0;
            end else begin
                m_dot++;
                if (m_dot == 456) begin
                    m_dot = 0;
                    m_ly++;
                    if (m_ly == 144) m_vbp = 1'b1;
                    if (m_ly == 154) begin
                        m_ly    = 0;
                        m_frame = (m_frame + 1) % 32;
                    end
                end
            end
            m_mode = mode_of(m_ly, m_dot);
            if (m_ly < 144 && m_dot >= 80 && m_dot < 240) begin
                m_rd   = 1'b1;
                m_addr = m_ly * 160 + (m_dot - 80);
                exp_q.push_back(expv(m_addr, m_ly, m_dot - 80, m_frame,
                                     pattern_sel));
            end
        end
    endtask

    // Called at a negedge: check, drive, predict, advance one clk.
    task automatic step(input bit en, input bit c);
        check_state();
        enable      = en;
        ce          = c;
        pattern_sel = 1'($urandom_range(0, 1));
        predict(en, c);
        @(negedge clk);
    endtask

    // Monitor: pops one expected pixel per clkena.
    initial begin
        logic [14:0] e;
        bit prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (clkena) begin
                chk("clkena_follows_rd", prev_rd, 1);
                chk("pending_at_clkena", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pixel_data", data, e);
                end
                n_clkena++;
                last_data = data;
                if (first_cyc < 0) first_cyc = cyc;
            end
            prev_rd = ram_rd;
        end
    end

    initial begin
        int guard;
        reset_n     = 1'b0;
        enable      = 1'b0;
        ce          = 1'b0;
        pattern_sel = 1'b0;
        salt        = '0;
        m_on = 0; m_run = 0; m_vbp = 0; m_rd = 0;
        m_dot = 0; m_ly = 0; m_frame = 0; m_mode = 0; m_addr = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {data, clkena, mode, on, ly, vblank_pulse, frame_cnt,
             ram_rd, ram_addr}, 0);
        reset_n = 1'b1;
        step(0, 1);
        step(0, 1);

        // Full frame with ce every clk and ram_q = ram_addr.
        start_cyc = cyc + 1;
        guard = 0;
        do begin
            step(1, 1);
            if (vblank_pulse) begin
                n_vbp++;
                chk("vblank_ly_mode", {ly, mode}, {8'd144, 2'd1});
            end
            guard++;
        end while (!(m_frame == 1 && m_ly == 0 && m_dot == 20) &&
                   guard < 71000);
        chk("frame_a_reached", guard < 71000, 1);
        repeat (3) step(0, 1);
        chk("frame_clkena_count", n_clkena, 23040);
        chk("frame_last_data", last_data, 23039);
        chk("vblank_pulse_count", n_vbp, 1);
        chk("first_clkena_clk", first_cyc - start_cyc + 1, 82);
        chk("frame_cnt_after_wrap", frame_cnt, 1);

        // ce every 4th clk for two lines, scrambled frame store.
        salt = 15'($urandom);
        guard = 0;
        do begin
            step(1, (guard % 4) == 0);
            guard++;
        end while (m_ly < 2 && guard < 5000);
        chk("ce_div4_two_lines_clks", guard, 2 * 1824 + 1);

        // Random ce until line 10 dot 120, then drop enable.
        guard = 0;
        do begin
            step(1, $urandom_range(0, 3) != 0);
            guard++;
        end while (!(m_ly == 10 && m_dot == 120) && guard < 20000);
        chk("reach_line10_dot120", guard < 20000, 1);
        repeat (6) step(0, 1'($urandom_range(0, 1)));

        // Re-enable; run until a read is issued mid mode 3.
        guard = 0;
        do begin
            step(1, $urandom_range(0, 1) != 0);
            guard++;
        end while (!(m_rd && m_dot >= 100) && guard < 2000);
        chk("reach_mid_xfer_read", guard < 2000, 1);

        // Asynchronous reset while ram_rd is high.
        check_state();
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {data, clkena, mode, on, ly, vblank_pulse, frame_cnt,
             ram_rd, ram_addr}, 0);
        m_on = 0; m_run = 0; m_vbp = 0; m_rd = 0;
        m_dot = 0; m_ly = 0; m_frame = 0; m_mode = 0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (1500) step(1, $urandom_range(0, 3) != 0);
        repeat (3) step(0, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lcd_stream_tx.md
Name: lcd_stream_tx

Overview:
Transmit side of the LCD pixel-stream interface. Reads 15-bit pixels from a line-ordered frame store and drives data/clkena/mode with DMG/CGB dot timing: 456 dots/line, 154 lines/frame, modes 2/3/0/1. Feeds the LCD framebuffer writer for replay, screenshot playback and bring-up without the PPU.

Parameters:
LINE_DOTS, 456, dots per line
OAM_DOTS, 80, mode-2 length in dots
XFER_DOTS, 172, mode-3 length in dots (the first VIS_W dots carry pixels)
VIS_W, 160, visible pixels per line
VIS_H, 144, visible lines
TOTAL_LINES, 154, lines per frame including vblank

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  dot enable; one dot per clk cycle with ce=1
enable  in  1  LCD on; low holds the block idle
pattern_sel  in  1  test-pattern select (used only with LCD_TX_PATTERN_EN)
ram_addr  out  15  frame-store read address, line*160+x
ram_rd  out  1  read strobe; ram_q is valid on the next clk
ram_q  in  15  frame-store read data
data  out  15  pixel to LCD (CGB RGB555, or DMG shade in [1:0])
clkena  out  1  one-clk pixel-valid strobe
mode  out  2  0 hblank, 1 vblank, 2 OAM, 3 transfer
on  out  1  registered copy of enable
ly  out  8  current line 0..153
vblank_pulse  out  1  one-clk pulse on entry to line VIS_H
frame_cnt  out  5  wrapping frame counter

Behaviour:
- Reset (async, reset_n=0): dot=0, ly=0, mode=0, on=0, clkena=0, ram_rd=0, data=0, ram_addr=0, pix_addr=0, frame_cnt=0, vblank_pulse=0.
- enable=0: next clk forces the same state as reset, except frame_cnt holds. An in-flight read is discarded and no clkena is produced. on follows enable with 1 clk delay.
- enable 0->1: the first ce starts at line 0, dot 0, mode 2.
- Counters advance only on ce. dot wraps from LINE_DOTS-1 to 0 and increments ly. ly wraps from TOTAL_LINES-1 to 0, increments frame_cnt (mod 32) and clears pix_addr.
- mode is registered from the updated dot/ly:
  - ly>=VIS_H: mode 1.
  - Otherwise dot<OAM_DOTS: mode 2.
  - Otherwise dot<OAM_DOTS+XFER_DOTS: mode 3.
  - Otherwise mode 0.
- Pixel fetch:
  - On each ce cycle with mode 3 and x=dot-OAM_DOTS<VIS_W, the block drives ram_rd=1 with ram_addr=pix_addr for one clk, then pix_addr+1.
  - pix_addr is an incrementing 15-bit counter, no multiplier; final value 23040 at end of visible frame.
- Return path: on the clk after ram_rd, data<=ram_q and clkena=1 for exactly one clk.
  - With ce every clk this yields 160 consecutive clkena cycles per line, lagging issue by 1 clk.
  - A read issued on the last transfer dot still returns while mode already shows 3. clkena is never produced while mode=1.
  - Exactly 23040 clkena pulses per frame.
- data holds its last value when clkena=0.
- vblank_pulse: one clk on the cycle ly becomes VIS_H, coincident with mode becoming 1.
- ce low stalls the timing; an outstanding read still completes on the next clk.
- Simultaneous enable fall and pending read: enable wins, no clkena.

Optional Feature:
LCD_TX_PATTERN_EN. When defined and pattern_sel=1, the RAM is still addressed and ram_rd still toggles, but data is replaced with a generated pattern:
- data[4:0]=x[7:3]
- data[9:5]=ly[7:3]
- data[14:10]=frame_cnt
The pattern uses the same 1-clk latency and the same clkena timing.
When undefined, pattern_sel is ignored, no pattern logic is synthesized, and data always comes from ram_q.

Test Plan:
- Reset, enable=1, ce every clk, ram_q=ram_addr -> mode 2 for 80 clk, mode 3 for 172, mode 0 for 204. Line 0 yields 160 clkena with data 0..159, first clkena at clk 82.
- Full frame -> 23040 clkena pulses, last data=23039. vblank_pulse once at ly=144 with mode=1. ly wraps 153->0 after 70224 dots, frame_cnt=1.
- ce asserted every 4th clk -> line length 1824 clk. Each clkena lands 1 clk after its ram_rd. Data sequence is unchanged.
- enable dropped at line 10, dot 120 -> next clk mode=0, ly=0, no further clkena. Re-enable restarts at ram_addr=0, mode 2.
- reset_n asserted mid-mode-3 with ram_rd high -> all outputs 0 immediately. No clkena after reset_n release until the next frame start.
- With LCD_TX_PATTERN_EN defined, pattern_sel=1, frame 3, ly=17, x=42 -> data=15'b00011_00010_00101.
